clock_set_buttons: RTL
======================

Name: clock_set_buttons

Overview:
- Upstream conditioner for the hour/minute setting chain.
- Takes the three raw, active-low front-panel push-buttons (MODE, UP, DOWN) and synchronises and debounces them.
- Produces the `set_ena` level and the active-low single-cycle `up`/`down` step pulses consumed by `hour_control` and its siblings.
- Adds auto-repeat on held UP/DOWN and an inactivity timeout that drops `set_ena`.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a button level change.
- REPEAT_DELAY, 16, cycles from the first pulse to the first auto-repeat pulse while held.
- REPEAT_RATE, 4, cycles between subsequent auto-repeat pulses.
- SET_TIMEOUT, 64, cycles without activity in set mode before `set_ena` clears.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_mode_n  in  1  raw MODE button, asynchronous, 0 = pressed.
- btn_up_n  in  1  raw UP button, asynchronous, 0 = pressed.
- btn_down_n  in  1  raw DOWN button, asynchronous, 0 = pressed.
- set_ena  out  1  registered; 1 = set mode.
- up  out  1  registered, active-low; one-cycle 0 = increment step.
- down  out  1  registered, active-low; one-cycle 0 = decrement step.

Behaviour:
- **Reset** (rst_n=0, async): synchronisers and debounced levels = 1 (released); counters = 0; FSMs = IDLE; set_ena=0, up=1, down=1.
- **Synchroniser:** 2-flop per button.
- **Debounce:** a per-button counter counts cycles where the synchronised value differs from the debounced level, and clears on agreement. When it reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
- **Press event:** debounced level goes 1->0. Release events generate nothing.
- **Latency:** let E0 be the first edge sampling raw=0. The debounced level falls at edge E(1+DEBOUNCE_CYCLES), and the output pulse is low for the one cycle after edge E(2+DEBOUNCE_CYCLES). With the default, that is after E6.
- **MODE press:** toggles set_ena at the next edge and clears the timeout counter.
- **UP/DOWN FSM** (one per button), states IDLE, DELAY, REPEAT, LOCK:
  - IDLE: on a press with set_ena=1, no MODE press this cycle, and the other button's debounced level =1, pulse and go to DELAY (counter=0). On a press otherwise, go to LOCK with no pulse.
  - DELAY: while held, count; at count REPEAT_DELAY-1 pulse and go to REPEAT (counter=0). On release, go to IDLE.
  - REPEAT: while held, pulse every REPEAT_RATE cycles. On release, go to IDLE.
  - LOCK: no pulses; go to IDLE only on release.
  - Any state except IDLE goes to LOCK when either of these holds:
    - both buttons are debounced-pressed;
    - set_ena clears (MODE or timeout).
  - Result: a held button does not resume when the other button is released; it must be re-pressed.
- **Pulse exclusivity:** up and down are never low in the same cycle. Each pulse is exactly one cycle low.
- **Timeout:**
  - While set_ena=1, the counter increments every cycle.
  - It clears on any output pulse, MODE press, or held-button state change.
  - When it reaches SET_TIMEOUT-1, set_ena goes 0 at the next edge and the counter clears.
  - While set_ena=0, the counter is held at 0.
- **Simultaneous MODE and UP/DOWN press in the same cycle:** MODE wins and the UP/DOWN press goes to LOCK.
- **Reset mid-repeat:** outputs return to 1 immediately (async); no pulse is generated after reset deassertion until a fresh debounced press.

Test Plan:
1. **Reset:** assert rst_n=0 mid-operation with up pulsing -> set_ena=0, up=1, down=1 within the same cycle. Hold all buttons released after deassertion -> outputs unchanged for 50 cycles.
2. **Bounce rejection:** set_ena=1, drive btn_up_n low for 3 cycles, high 1, low 2, high -> up stays 1 throughout.
3. **Single step:** press MODE for 10 cycles -> set_ena=1. Press UP at E0 for 10 cycles -> up=0 only for the cycle after E6, then stays 1. Exactly one pulse.
4. **Auto-repeat:** set_ena=1, hold DOWN 40 cycles after the first pulse at cycle P -> down pulses at P, P+16, P+20, P+24, P+28, P+32, P+36, P+40 (8 pulses, each one cycle). Release -> no further pulses.
5. **Conflict:** hold UP (pulsing), then press DOWN -> no pulses on either while both held. Release DOWN, keep UP -> up stays 1 until UP is released and re-pressed.
6. **Timeout / gating:** enter set mode, no activity for 64 cycles -> set_ena falls at the 64th edge. Then press UP -> up stays 1. A MODE press during the count restarts the 64-cycle window (set_ena toggles off, second MODE on, full 64 again).

Source files
------------

// File: rtl/clock_set_buttons.sv
// Front-panel button conditioner for the clock setting chain: synchronises and
// debounces MODE/UP/DOWN, toggles set mode, and produces active-low
// single-cycle up/down step pulses with auto-repeat and a set-mode timeout.
module clock_set_buttons #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 4,
  parameter int SET_TIMEOUT     = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_mode_n,
  input  logic btn_up_n,
  input  logic btn_down_n,
  output logic set_ena,
  output logic up,
  output logic down
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int TW   = $clog2(SET_TIMEOUT);

  // Per-button step machine: IDLE waits for a press, DELAY waits for the first
  // auto-repeat, REPEAT steps at the repeat rate, LOCK swallows the press.
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT, S_LOCK} state_e;

  // Button vectors are indexed [0]=MODE, [1]=UP, [2]=DOWN.
  logic [2:0]    raw_n;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    deb_q, deb_d, deb_prev_q;
  logic [DW-1:0] dcnt_q [3];
  logic [DW-1:0] dcnt_d [3];

  // Step-machine vectors are indexed [0]=UP, [1]=DOWN.
  logic [2:0]    press;
  logic          mode_press;
  logic [1:0]    press_ud, held, other_rel, ud_change;
  logic          both_held, lock_pre;
  state_e        state_q [2];
  state_e        state_d [2];
  logic [RW-1:0] rcnt_q [2];
  logic [RW-1:0] rcnt_d [2];
  logic [1:0]    pulse;
  logic          activity, timeout_hit, set_clear;

  logic          set_ena_q, set_ena_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          up_q, down_q;

  assign raw_n      = {btn_down_n, btn_up_n, btn_mode_n};
  assign press      = deb_prev_q & ~deb_q;              // debounced 1->0 only
  assign mode_press = press[0];
  assign press_ud   = press[2:1];
  assign held       = ~deb_q[2:1];
  assign other_rel  = {deb_q[1], deb_q[2]};             // the opposite button is released
  assign ud_change  = deb_prev_q[2:1] ^ deb_q[2:1];
  assign both_held  = &held;
  assign lock_pre   = both_held | (set_ena_q & mode_press);

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can infer a latch.
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) deb_d[i] = sync2_q[i];
        else                                       dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
    end
  end

  // Synchronisers, debounced levels and their one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      deb_prev_q <= '1;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so each flop samples its source's pre-edge value.
      sync1_q    <= raw_n;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  // Step decisions, step-machine next state, set-mode toggle and inactivity timeout.
  always_comb begin
    pulse     = '0;
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    set_ena_d = set_ena_q;
    tcnt_d    = tcnt_q;

    // A step is only issued while the other button is up and set mode is not being left.
    for (int b = 0; b < 2; b++) begin
      case (state_q[b])
        S_IDLE:   pulse[b] = press_ud[b] & set_ena_q & ~mode_press & other_rel[b];
        S_DELAY:  pulse[b] = held[b] & ~lock_pre & (rcnt_q[b] == RW'(REPEAT_DELAY - 1));
        S_REPEAT: pulse[b] = held[b] & ~lock_pre & (rcnt_q[b] == RW'(REPEAT_RATE - 1));
        default:  pulse[b] = 1'b0;
      endcase
    end

    // Activity in this cycle pre-empts the timeout.
    activity    = (|pulse) | mode_press | (|ud_change);
    timeout_hit = set_ena_q & ~activity & (tcnt_q == TW'(SET_TIMEOUT - 1));
    set_clear   = set_ena_q & (mode_press | timeout_hit);

    if (!set_ena_q) begin
      tcnt_d = '0;
      if (mode_press) set_ena_d = 1'b1;
    end else if (mode_press || timeout_hit) begin
      set_ena_d = 1'b0;
      tcnt_d    = '0;
    end else if (activity) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end

    // Once locked, a button stays silent until it is physically released.
    for (int b = 0; b < 2; b++) begin
      if (state_q[b] == S_IDLE) begin
        if (press_ud[b]) begin
          state_d[b] = pulse[b] ? S_DELAY : S_LOCK;
          rcnt_d[b]  = '0;
        end
      end else if (!held[b]) begin
        state_d[b] = S_IDLE;
        rcnt_d[b]  = '0;
      end else if (both_held || set_clear) begin
        state_d[b] = S_LOCK;
        rcnt_d[b]  = '0;
      end else if (state_q[b] != S_LOCK) begin
        if (pulse[b]) begin
          state_d[b] = S_REPEAT;
          rcnt_d[b]  = '0;
        end else begin
          rcnt_d[b]  = rcnt_q[b] + 1'b1;
        end
      end
    end
  end

  // State registers and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= S_IDLE;
        rcnt_q[b]  <= '0;
      end
      set_ena_q <= 1'b0;
      tcnt_q    <= '0;
      up_q      <= 1'b1;
      down_q    <= 1'b1;
    end else begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= state_d[b];
        rcnt_q[b]  <= rcnt_d[b];
      end
      set_ena_q <= set_ena_d;
      tcnt_q    <= tcnt_d;
      up_q      <= ~pulse[0];
      down_q    <= ~pulse[1];
    end
  end

  assign set_ena = set_ena_q;
  assign up      = up_q;
  assign down    = down_q;

endmodule
